// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial sequence detector.
// The optional match counter is enabled by defining SEQ_DET_CNT_EN.
package seq_det_pkg;

   localparam int PAT_W_DEF = 8;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      UNCFG = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2
   } state_e;

endpackage

// File: rtl/seq_det_hist.sv
// History shift register and fill counter for seq_det_prog.
// full means the history holds len-1 bits once this cycle's shift has landed.
module seq_det_hist #(
   parameter int PAT_W = 8,
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift,
   input  logic             x,
   input  logic [LEN_W-1:0] len,
   output logic [PAT_W-2:0] hist,
   output logic             full
);

   logic [LEN_W-1:0] fill;
   logic [PAT_W-2:0] hist_nx;
   logic [31:0]      fill_ext;
   logic [31:0]      len_ext;

   assign fill_ext = 32'(fill);
   assign len_ext  = 32'(len);

   // Lookahead so the FSM can enter RUN on the same edge the last fill bit lands.
   assign full = (fill_ext + 32'd1 == len_ext) ||
                 (shift && (fill_ext + 32'd2 == len_ext));

   always_comb begin
      hist_nx    = hist;
      hist_nx[0] = x;
      for (int i = 1; i < PAT_W - 1; i++) begin
         hist_nx[i] = hist[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= hist_nx;
         if (fill_ext + 32'd1 < len_ext) begin
            fill <= fill + LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/seq_det_prog.sv
// Programmable serial sequence detector with Mealy match output.
// Define SEQ_DET_CNT_EN to build the saturating match counter; otherwise match_cnt is 0.
module seq_det_prog
   import seq_det_pkg::*;
#(
   parameter int PAT_W = PAT_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x,
   input  logic             in_valid,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic [LEN_W-1:0] len_in,
   input  logic             overlap,
   output logic             y,
   output logic             armed,
   output logic [CNT_W-1:0] match_cnt,
   output logic [1:0]       fsm_state
);

   localparam logic [1:0] S_UNCFG = UNCFG;
   localparam logic [1:0] S_FILL  = FILL;
   localparam logic [1:0] S_RUN   = RUN;

   logic [1:0]       state;
   logic [1:0]       state_nx;
   logic [PAT_W-1:0] pat;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] len_nx;
   logic             ovl;
   logic [PAT_W-2:0] hist;
   logic             full;
   logic [PAT_W-1:0] mask;
   logic [PAT_W-1:0] cand;
   logic             load_ok;
   logic             acc_bit;
   logic             hit;
   logic             clr;

   assign load_ok = pat_load && (len_in != '0) && (32'(len_in) <= 32'(PAT_W));
   assign acc_bit = !rst && in_valid && !load_ok && (state != S_UNCFG);
   assign cand    = {hist, x};
   assign hit     = ((cand ^ pat) & mask) == '0;
   assign y       = acc_bit && ((state == S_RUN) || (len == LEN_W'(1))) && hit;
   assign clr     = load_ok || (y && !ovl);
   assign len_nx  = load_ok ? len_in : len;
   assign fsm_state = state;

   always_comb begin
      mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         mask[i] = (32'(i) < 32'(len));
      end
   end

   always_comb begin
      state_nx = state;
      if (load_ok) begin
         state_nx = S_FILL;
      end else if (acc_bit) begin
         if (y && !ovl) begin
            state_nx = S_FILL;
         end else if ((state == S_FILL) && full) begin
            state_nx = S_RUN;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_UNCFG;
         pat   <= '0;
         len   <= '0;
         ovl   <= 1'b0;
         armed <= 1'b0;
      end else begin
         state <= state_nx;
         if (load_ok) begin
            pat <= pat_in;
            len <= len_in;
            ovl <= overlap;
         end
         armed <= (state_nx == S_RUN) ||
                  ((state_nx != S_UNCFG) && (len_nx == LEN_W'(1)));
      end
   end

   seq_det_hist #(
      .PAT_W (PAT_W),
      .LEN_W (LEN_W)
   ) u_hist (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .shift (acc_bit),
      .x     (x),
      .len   (len),
      .hist  (hist),
      .full  (full)
   );

`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || load_ok) begin
         cnt <= '0;
      end else if (y && (cnt != '1)) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign match_cnt = cnt;
`else
   assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_det_prog.sv
// Scoreboard bench for seq_det_prog: driver pushes expected y/armed/match_cnt per cycle,
// a negedge monitor pops and compares. Counter expectations follow SEQ_DET_CNT_EN.
module tb_seq_det_prog;

   localparam int PAT_W = 8;
   localparam int CNT_W = 2;
   localparam int LEN_W = 4;
   localparam int EW    = 4 + CNT_W;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             x;
   logic             in_valid;
   logic             pat_load;
   logic [PAT_W-1:0] pat_in;
   logic [LEN_W-1:0] len_in;
   logic             overlap;
   logic             y;
   logic             armed;
   logic [CNT_W-1:0] match_cnt;
   logic [1:0]       fsm_state;

   logic [EW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_match  = 0;

   always #5 clk = ~clk;

   seq_det_prog #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W),
      .LEN_W (LEN_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .in_valid  (in_valid),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
      .len_in    (len_in),
      .overlap   (overlap),
      .y         (y),
      .armed     (armed),
      .match_cnt (match_cnt),
      .fsm_state (fsm_state)
   );

   function automatic logic [CNT_W-1:0] cnt_model(input int n);
`ifdef SEQ_DET_CNT_EN
      return (n > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(n);
`else
      return '0;
`endif
   endfunction

   // One clock cycle of stimulus; ea = -1 skips the armed/match_cnt checks.
   task automatic drive(input logic rs, input logic ld, input logic [PAT_W-1:0] p,
                        input logic [LEN_W-1:0] l, input logic ov, input logic v,
                        input logic xb, input logic ey, input int ea);
      logic ld_ok;
      rst      = rs;
      pat_load = ld;
      pat_in   = p;
      len_in   = l;
      overlap  = ov;
      in_valid = v;
      x        = xb;
      exp_q.push_back({ea >= 0, ea == 1, ea >= 0, cnt_model(n_match), ey});
      ld_ok = ld && (l >= 1) && (l <= PAT_W);
      if (rs || ld_ok) n_match = 0;
      else if (ey) n_match++;
      @(posedge clk);
      #1;
   endtask

   task automatic tick(input logic v, input logic xb, input logic ey, input int ea);
      drive(1'b0, 1'b0, '0, '0, 1'b0, v, xb, ey, ea);
   endtask

   task automatic load(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic ov,
                       input logic v, input logic xb, input int ea);
      drive(1'b0, 1'b1, p, l, ov, v, xb, 1'b0, ea);
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         logic [EW-1:0] e;
         e = exp_q.pop_front();
         n_checks++;
         if (y !== e[0]) begin
            n_fail++;
            $display("FAIL y: got %b expected %b at %0t", y, e[0], $time);
         end
         if (e[CNT_W+1]) begin
            n_checks++;
            if (match_cnt !== e[CNT_W:1]) begin
               n_fail++;
               $display("FAIL match_cnt: got %0d expected %0d at %0t", match_cnt, e[CNT_W:1], $time);
            end
         end
         if (e[EW-1]) begin
            n_checks++;
            if (armed !== e[EW-2]) begin
               n_fail++;
               $display("FAIL armed: got %b expected %b at %0t", armed, e[EW-2], $time);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; x = 1'b0; in_valid = 1'b0; pat_load = 1'b0;
      pat_in = '0; len_in = '0; overlap = 1'b0;
      @(posedge clk);
      #1;
      // Reset beats a simultaneous load and valid bit.
      drive(1'b1, 1'b1, 8'b101, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, -1);
      tick(0, 0, 0, 0);
      tick(1, 1, 0, 0);
      // Illegal lengths are ignored.
      load(8'b101, 4'd0, 1'b1, 0, 0, 0);
      load(8'b101, 4'd9, 1'b1, 0, 0, 0);
      tick(1, 1, 0, 0);
      // Overlapping 101 on 10101.
      load(8'b101, 4'd3, 1'b1, 0, 0, 0);
      tick(1, 1, 0, 0); tick(1, 0, 0, 0); tick(1, 1, 1, 1); tick(1, 0, 0, 1); tick(1, 1, 1, 1);
      tick(0, 0, 0, 1);
      // Non-overlapping 101 on 10101.
      load(8'b101, 4'd3, 1'b0, 0, 0, 1);
      tick(1, 1, 0, 0); tick(1, 0, 0, 0); tick(1, 1, 1, 1); tick(1, 0, 0, 0); tick(1, 1, 0, 0);
      tick(0, 0, 0, 1);
      // Full-width pattern.
      load(8'b11010011, 4'd8, 1'b1, 0, 0, 1);
      tick(1, 1, 0, 0); tick(1, 1, 0, 0); tick(1, 0, 0, 0); tick(1, 1, 0, 0);
      tick(1, 0, 0, 0); tick(1, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 1, 1, 1);
      tick(0, 0, 0, 1);
      // Reload collides with a valid bit: the bit is dropped and history restarts.
      load(8'b101, 4'd3, 1'b1, 0, 0, 1);
      tick(1, 1, 0, 0); tick(1, 0, 0, 0);
      load(8'b101, 4'd3, 1'b1, 1, 1, 1);
      tick(1, 0, 0, 0); tick(1, 1, 0, 0); tick(1, 0, 0, 1); tick(1, 1, 1, 1);
      // Gaps with x=1 must not match or shift.
      load(8'b101, 4'd3, 1'b1, 0, 0, 1);
      tick(1, 1, 0, 0); tick(0, 1, 0, 0); tick(1, 0, 0, 0); tick(0, 1, 0, 1); tick(0, 1, 0, 1);
      tick(1, 1, 1, 1);
      // Single-bit pattern, counter saturation, then reset mid-stream.
      load(8'b1, 4'd1, 1'b1, 0, 0, 1);
      for (int i = 0; i < 5; i++) tick(1, 1, 1, 1);
      tick(1, 0, 0, 1);
      tick(0, 0, 0, 1);
      drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
      tick(1, 1, 0, 0); tick(1, 1, 0, 0);
      load(8'b1, 4'd1, 1'b1, 0, 0, 0);
      tick(1, 1, 1, 1);
      tick(0, 0, 0, 1);
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_det_prog.md
SEQ_DET_PROG -- requirements
Module: seq_det_prog

Interface
REQ-001 Parameter PAT_W, default 8: maximum pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 8: match counter width.
REQ-003 Parameter LEN_W, default $clog2(PAT_W+1): width of the length port.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 x  input  1  serial data bit.
REQ-007 in_valid  input  1  x is sampled only when this is 1.
REQ-008 pat_load  input  1  load pat_in, len_in and overlap this cycle.
REQ-009 pat_in  input  PAT_W  pattern; pat_in[len-1] is the first bit received and pat_in[0] is the last.
REQ-010 len_in  input  LEN_W  pattern length.
REQ-011 overlap  input  1  1 = overlapping detection, 0 = non-overlapping detection.
REQ-012 y  output  1  Mealy match flag.
REQ-013 armed  output  1  a pattern has been loaded and the history is full.
REQ-014 match_cnt  output  CNT_W  saturating count of matches.

Function
REQ-015 The FSM SHALL have three states: UNCFG (no pattern), FILL (history holds fewer than len-1 bits) and RUN.
REQ-016 Transitions: UNCFG->FILL on an accepted load; FILL->RUN when fill reaches len-1; RUN->FILL on a non-overlap match or an accepted load; any state->UNCFG on rst.
REQ-017 An accepted load SHALL require pat_load=1 with 1 <= len_in <= PAT_W; a load with len_in=0 or len_in>PAT_W SHALL be ignored with all state unchanged.
REQ-018 An accepted load SHALL latch the pattern, length and mode, clear the history and set fill to 0; the new pattern is effective from the next cycle.
REQ-019 When an accepted load and in_valid occur in the same cycle, the load SHALL win: x is discarded and y=0.
REQ-020 On an accepted bit (in_valid=1, no accepted load, state not UNCFG), the history SHALL shift left with x entering the LSB, and fill SHALL increment, saturating at len-1.
REQ-021 y SHALL be combinational in the same cycle: y = in_valid & (state==RUN or len==1, with state not UNCFG) & ({hist[len-2:0], x} == pat[len-1:0]).
REQ-022 y SHALL be 0 whenever in_valid=0, in UNCFG, or in a cycle with an accepted load.
REQ-023 With overlap=1, a match SHALL leave the history and fill intact (pattern 101 on stream 10101 gives 2 matches).
REQ-024 With overlap=0, a match SHALL clear the fill to 0 and return the FSM to FILL (pattern 101 on stream 10101 gives 1 match).
REQ-025 armed SHALL be a registered output equal to (state==RUN), or 1 in FILL/RUN when len==1.
REQ-026 Cycles with in_valid=0 SHALL not alter the history, fill or state.

Reset
REQ-027 rst=1 at a clock edge SHALL force the following: state UNCFG, history 0, fill 0, pattern 0, len 0, overlap 0, match_cnt 0, armed 0.
REQ-028 While rst=1, y SHALL be 0, and rst SHALL take priority over pat_load and in_valid.

Configuration
REQ-029 The macro SEQ_DET_CNT_EN SHALL control the match counter.
REQ-030 With SEQ_DET_CNT_EN defined, match_cnt SHALL increment on every cycle with y=1, saturate at all-ones, and clear on an accepted load.
REQ-031 Without SEQ_DET_CNT_EN, no counter flops SHALL exist and match_cnt SHALL be tied to 0.

Structure
REQ-032 The shared package seq_det_pkg SHALL hold the FSM state enum (UNCFG, FILL, RUN) and the default PAT_W/CNT_W constants.
REQ-033 The history shift register plus fill counter SHALL be a sub-module named seq_det_hist, with ports clk, rst, clr, shift, x, len, hist and full.

Verification
REQ-034 PAT_W=8; load pat=101, len=3, overlap=1; send 1,0,1,0,1 with in_valid=1 -> y=1 on bits 3 and 5 only; match_cnt=2.
REQ-035 Same stream with overlap=0 -> y=1 on bit 3 only; bit 5 gives no match; match_cnt=1.
REQ-036 Load pat=8'b11010011, len=8; send 1,1,0,1,0,0,1,1 -> armed=1 after bit 7; y=1 on bit 8 only.
REQ-037 Pattern 101 loaded; send 1,0, then reload 101 in the same cycle as an in_valid bit 1 -> y=0 that cycle and the next two bits; match only after a fresh 1,0,1.
REQ-038 Pattern 101 with in_valid gaps (1,-,0,-,-,1) -> y=1 only in the cycle carrying the final 1; y=0 in all gap cycles.
REQ-039 CNT_W=2 with SEQ_DET_CNT_EN defined, 5 matches -> match_cnt=3; rst mid-stream -> match_cnt=0, armed=0 and y stays 0 until a reload.
